// File: rtl/i2s_slave_rx_pkg.sv
// ============================================================================
// i2s_slave_rx_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the I2S slave receiver:
//   - default sample / slot widths and synchroniser depth
//   - bit counter width and a saturating increment helper
//   - FSM state encoding (IDLE / WAIT_L / WAIT_R, 2 bits)
// ============================================================================
package i2s_slave_rx_pkg;

    localparam int I2S_SAMPLE_WIDTH = 16;
    localparam int I2S_SLOT_WIDTH   = 32;
    localparam int I2S_SYNC_STAGES  = 2;
    localparam int I2S_CNT_WIDTH    = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT_L = 2'b01,
        ST_WAIT_R = 2'b10
    } i2s_state_t;

    // Counts BCLK rises within a slot; sticks at all-ones instead of wrapping
    // so that a grossly long slot can never alias to a legal length.
    function automatic logic [I2S_CNT_WIDTH-1:0] sat_inc(
        input logic [I2S_CNT_WIDTH-1:0] cnt
    );
        if (cnt == {I2S_CNT_WIDTH{1'b1}}) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

endpackage : i2s_slave_rx_pkg

// File: rtl/i2s_slave_rx_sync_edge.sv
// ============================================================================
// i2s_slave_rx_sync_edge
// ----------------------------------------------------------------------------
// STAGES-deep synchroniser for one asynchronous input, followed by a
// rise/fall detector on the synchronised level.
//
// Ports:
//   i_clk   in   system clock
//   i_rst   in   asynchronous active-high reset
//   i_d     in   asynchronous input line
//   o_q     out  synchronised level
//   o_rise  out  1-cycle strobe: synchronised level went 0 -> 1
//   o_fall  out  1-cycle strobe: synchronised level went 1 -> 0
//
// The strobes are combinational from the last synchroniser stage, so a pin
// change becomes visible on the strobes STAGES clocks later and anything
// registered from a strobe appears STAGES+1 clocks after the pin change.
// ============================================================================
module i2s_slave_rx_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] w_sync_d;
    logic              r_prev;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign w_sync_d[gi] = i_d;
            end else begin : g_chain
                assign w_sync_d[gi] = r_sync[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= w_sync_d;
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule : i2s_slave_rx_sync_edge

// File: rtl/i2s_slave_rx.sv
// ============================================================================
// i2s_slave_rx
// ----------------------------------------------------------------------------
// Stereo I2S slave receiver. BCLK, LRCK and SDATA are driven by an external
// master and oversampled in the clk domain. Left and right samples are
// deserialised MSB first (standard I2S, 1-bit delay after each LRCK edge) and
// each complete stereo frame is presented with a 1-cycle valid pulse at the
// LRCK falling edge that closes the right slot.
//
// Ports:
//   i_clk           in   system clock
//   i_reset         in   asynchronous active-high reset
//   i_bclk_in       in   I2S bit clock (asynchronous)
//   i_lrck_in       in   I2S word select, 0 = left, 1 = right
//   i_sdata_in      in   I2S serial data
//   o_sample_l      out  last complete left sample (two's complement)
//   o_sample_r      out  last complete right sample (two's complement)
//   o_sample_valid  out  1-cycle pulse: o_sample_l / o_sample_r updated
//   o_frame_err     out  1-cycle pulse on a malformed slot
//
// Build option:
//   I2S_RX_FRAME_CHECK_EN  when defined, a slot with fewer than
//                          SAMPLE_WIDTH+1 or more than SLOT_WIDTH+1 BCLK rises
//                          pulses o_frame_err at its closing LRCK edge and the
//                          frame is dropped. When undefined, o_frame_err is 0
//                          and only short slots are dropped.
// ============================================================================
module i2s_slave_rx
    import i2s_slave_rx_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
    parameter int SYNC_STAGES  = I2S_SYNC_STAGES
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_bclk_in,
    input  logic                    i_lrck_in,
    input  logic                    i_sdata_in,
    output logic [SAMPLE_WIDTH-1:0] o_sample_l,
    output logic [SAMPLE_WIDTH-1:0] o_sample_r,
    output logic                    o_sample_valid,
    output logic                    o_frame_err
);

    // Minimum rise count for a usable slot: the delay bit plus every sample bit.
    localparam logic [I2S_CNT_WIDTH-1:0] MIN_CNT    = I2S_CNT_WIDTH'(SAMPLE_WIDTH + 1);
    // Last rise (counted before increment) whose data is still a sample bit.
    localparam logic [I2S_CNT_WIDTH-1:0] SHIFT_LAST = I2S_CNT_WIDTH'(SAMPLE_WIDTH);
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam logic [I2S_CNT_WIDTH-1:0] MAX_CNT    = I2S_CNT_WIDTH'(SLOT_WIDTH + 1);
`endif

    // ------------------------------------------------------------------
    // Input synchronisation and edge strobes
    // ------------------------------------------------------------------
    logic w_bclk_rise;
    logic w_bclk_fall_unused;
    logic w_bclk_level_unused;
    logic w_lrck_rise;
    logic w_lrck_fall;
    logic w_lrck_level_unused;
    logic w_sdata;
    logic w_sdata_rise_unused;
    logic w_sdata_fall_unused;

    i2s_slave_rx_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_bclk (
        .i_clk  (i_clk),
        .i_rst  (i_reset),
        .i_d    (i_bclk_in),
        .o_q    (w_bclk_level_unused),
        .o_rise (w_bclk_rise),
        .o_fall (w_bclk_fall_unused)
    );

    i2s_slave_rx_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_lrck (
        .i_clk  (i_clk),
        .i_rst  (i_reset),
        .i_d    (i_lrck_in),
        .o_q    (w_lrck_level_unused),
        .o_rise (w_lrck_rise),
        .o_fall (w_lrck_fall)
    );

    // Same depth as BCLK so each data bit lines up with its BCLK rise strobe.
    i2s_slave_rx_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_sdata (
        .i_clk  (i_clk),
        .i_rst  (i_reset),
        .i_d    (i_sdata_in),
        .o_q    (w_sdata),
        .o_rise (w_sdata_rise_unused),
        .o_fall (w_sdata_fall_unused)
    );

    logic w_lrck_edge;
    assign w_lrck_edge = w_lrck_rise | w_lrck_fall;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    i2s_state_t                r_state;
    i2s_state_t                w_state_next;
    logic [I2S_CNT_WIDTH-1:0]  r_bit_cnt;
    logic [SAMPLE_WIDTH-1:0]   r_shreg;
    logic [SAMPLE_WIDTH-1:0]   r_hold_l;
    logic                      r_l_ok;
    logic                      w_l_ok_next;
    logic                      w_load_hold;
    logic                      w_load_out;
    logic                      w_slot_ok;
    logic [SAMPLE_WIDTH-1:0]   r_sample_l;
    logic [SAMPLE_WIDTH-1:0]   r_sample_r;
    logic                      r_sample_valid;

    // Length check of the slot being closed, evaluated on the LRCK edge
    // strobe using the count accumulated before that edge.
`ifdef I2S_RX_FRAME_CHECK_EN
    assign w_slot_ok = (r_bit_cnt >= MIN_CNT) && (r_bit_cnt <= MAX_CNT);
`else
    assign w_slot_ok = (r_bit_cnt >= MIN_CNT);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_l_ok_next  = r_l_ok;
        w_load_hold  = 1'b0;
        w_load_out   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Lock on the first left-slot start; anything earlier is noise.
                if (w_lrck_fall) begin
                    w_state_next = ST_WAIT_L;
                    w_l_ok_next  = 1'b0;
                end
            end
            ST_WAIT_L: begin
                if (w_lrck_rise) begin
                    w_l_ok_next  = w_slot_ok;
                    w_load_hold  = w_slot_ok;
                    w_state_next = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (w_lrck_fall) begin
                    w_load_out   = r_l_ok & w_slot_ok;
                    w_l_ok_next  = 1'b0;
                    w_state_next = ST_WAIT_L;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_l_ok_next  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit counter, shift register, holding and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bit_cnt      <= '0;
            r_shreg        <= '0;
            r_hold_l       <= '0;
            r_l_ok         <= 1'b0;
            r_sample_l     <= '0;
            r_sample_r     <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            if (w_lrck_edge) begin
                // LRCK edge wins; a coincident BCLK rise is bit 1 of the new
                // slot (the previous slot's LSB), which carries no sample data.
                r_bit_cnt <= w_bclk_rise ? I2S_CNT_WIDTH'(1) : '0;
            end else if (w_bclk_rise) begin
                r_bit_cnt <= sat_inc(r_bit_cnt);
                // Rises 2..SAMPLE_WIDTH+1 (count 1..SAMPLE_WIDTH before the
                // increment) are sample bits, MSB first.
                if ((r_bit_cnt != '0) && (r_bit_cnt <= SHIFT_LAST)) begin
                    r_shreg <= {r_shreg[SAMPLE_WIDTH-2:0], w_sdata};
                end
            end

            if (w_load_hold) begin
                r_hold_l <= r_shreg;
            end

            r_l_ok         <= w_l_ok_next;
            r_sample_valid <= w_load_out;

            if (w_load_out) begin
                r_sample_l <= r_hold_l;
                r_sample_r <= r_shreg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame error pulse
    // ------------------------------------------------------------------
`ifdef I2S_RX_FRAME_CHECK_EN
    logic w_frame_err_det;
    logic r_frame_err;

    // Flag any badly sized slot at its closing edge while locked.
    assign w_frame_err_det = ((r_state == ST_WAIT_L) && w_lrck_rise && !w_slot_ok) ||
                             ((r_state == ST_WAIT_R) && w_lrck_fall && !w_slot_ok);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err_det;
        end
    end

    assign o_frame_err = r_frame_err;
`else
    assign o_frame_err = 1'b0;
`endif

    assign o_sample_l     = r_sample_l;
    assign o_sample_r     = r_sample_r;
    assign o_sample_valid = r_sample_valid;

endmodule : i2s_slave_rx

// File: tb/tb_i2s_slave_rx.sv
// ============================================================================
// tb_i2s_slave_rx
// ----------------------------------------------------------------------------
// Directed bench for i2s_slave_rx: an I2S master model with BCLK at 16 clk
// per phase and 32-bit slots, a negedge monitor that records valid pulses,
// and one task per scenario with inline expected-value comparisons.
// ============================================================================
module tb_i2s_slave_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        frame_err;

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam int EXP_SHORT_ERR = 1;
`else
    localparam int EXP_SHORT_ERR = 0;
`endif

    i2s_slave_rx dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_bclk_in      (bclk),
        .i_lrck_in      (lrck),
        .i_sdata_in     (sdata),
        .o_sample_l     (sample_l),
        .o_sample_r     (sample_r),
        .o_sample_valid (sample_valid),
        .o_frame_err    (frame_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every valid pulse and frame_err pulse.
    int          valid_cnt  = 0;
    int          err_cnt    = 0;
    int          wide_cnt   = 0;
    int          valid_cyc  = 0;
    int          fall_cyc   = 0;
    logic [15:0] cap_l      = '0;
    logic [15:0] cap_r      = '0;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
            cap_l     <= sample_l;
            cap_r     <= sample_r;
            if (prev_valid) wide_cnt <= wide_cnt + 1;
            $display("[%0d] frame L=%h R=%h", cyc, sample_l, sample_r);
        end
        if (frame_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            $display("[%0d] frame_err pulse", cyc);
        end
        prev_valid <= sample_valid;
    end

    int n_pass = 0;
    int n_chk  = 0;

    // ------------------------------------------------------------------
    // I2S master model (all tasks start and end on a clk negedge)
    // ------------------------------------------------------------------
    // One slot of nbits BCLK periods. Bit b is driven on the falling BCLK
    // edge; b = 0 is the 1-bit delay slot, b = 1..16 carry word MSB first,
    // the rest are filler ones. When late = 1, LRCK switches together with
    // the first BCLK rise instead of the preceding fall.
    task automatic send_slot(input logic ch, input logic [15:0] word,
                             input int nbits, input bit late);
        for (int b = 0; b < nbits; b++) begin
            bclk = 1'b0;
            if (!late && b == 0) lrck = ch;
            if (b >= 1 && b <= 16) sdata = word[16-b];
            else                   sdata = 1'b1;
            repeat (16) @(negedge clk);
            bclk = 1'b1;
            if (late && b == 0) lrck = ch;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 32, 1'b0);
        send_slot(1'b1, r, 32, 1'b0);
    endtask

    // LRCK falling edge that closes a right slot (and opens the next left).
    task automatic close_frame();
        bclk     = 1'b0;
        lrck     = 1'b0;
        sdata    = 1'b1;
        fall_cyc = cyc;
        repeat (8) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        bclk  = 1'b0;
        lrck  = 1'b1;
        sdata = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++;
        if (sample_l !== 16'h0000) $display("FAIL reset_sample_l: got %h, expected 0000", sample_l);
        else n_pass++;
        n_chk++;
        if (sample_r !== 16'h0000) $display("FAIL reset_sample_r: got %h, expected 0000", sample_r);
        else n_pass++;
        n_chk++;
        if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", sample_valid);
        else n_pass++;
        n_chk++;
        if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b, expected 0", frame_err);
        else n_pass++;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_chk++;
        if (valid_cnt !== 0 || err_cnt !== 0)
            $display("FAIL reset_idle_pulses: got valid=%0d err=%0d, expected 0/0", valid_cnt, err_cnt);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int v0;
        close_frame();                       // lock edge, no frame yet
        n_chk++;
        if (valid_cnt !== 0) $display("FAIL lock_no_valid: got %0d pulses, expected 0", valid_cnt);
        else n_pass++;
        v0 = valid_cnt;
        send_frame(16'h1234, 16'hABCD);
        close_frame();
        n_chk++;
        if (valid_cnt - v0 !== 1) $display("FAIL basic_count: got %0d pulses, expected 1", valid_cnt - v0);
        else n_pass++;
        n_chk++;
        if (cap_l !== 16'h1234) $display("FAIL basic_l: got %h, expected 1234", cap_l);
        else n_pass++;
        n_chk++;
        if (cap_r !== 16'hABCD) $display("FAIL basic_r: got %h, expected abcd", cap_r);
        else n_pass++;
        n_chk++;
        if (valid_cyc - fall_cyc !== 3)
            $display("FAIL basic_latency: got %0d clk, expected 3", valid_cyc - fall_cyc);
        else n_pass++;
        n_chk++;
        if (wide_cnt !== 0) $display("FAIL basic_width: got %0d wide pulses, expected 0", wide_cnt);
        else n_pass++;
        $display("test_basic done");
    endtask

    task automatic test_sweep();
        logic [15:0] tl [2];
        logic [15:0] tr [2];
        int          v0;
        tl[0] = 16'h8000; tr[0] = 16'h7FFF;
        tl[1] = 16'hFFFF; tr[1] = 16'h0001;
        for (int k = 0; k < 2; k++) begin
            v0 = valid_cnt;
            send_frame(tl[k], tr[k]);
            close_frame();
            n_chk++;
            if (valid_cnt - v0 !== 1) $display("FAIL sweep%0d_count: got %0d, expected 1", k, valid_cnt - v0);
            else n_pass++;
            n_chk++;
            if (cap_l !== tl[k]) $display("FAIL sweep%0d_l: got %h, expected %h", k, cap_l, tl[k]);
            else n_pass++;
            n_chk++;
            if (cap_r !== tr[k]) $display("FAIL sweep%0d_r: got %h, expected %h", k, cap_r, tr[k]);
            else n_pass++;
        end
        $display("test_sweep done");
    endtask

    task automatic test_short_slot();
        int v0;
        int e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_slot(1'b0, 16'h5555, 32, 1'b0);
        send_slot(1'b1, 16'h3C3C, 10, 1'b0);
        close_frame();
        n_chk++;
        if (valid_cnt - v0 !== 0) $display("FAIL short_count: got %0d pulses, expected 0", valid_cnt - v0);
        else n_pass++;
        n_chk++;
        if (sample_l !== 16'hFFFF || sample_r !== 16'h0001)
            $display("FAIL short_hold: got %h/%h, expected ffff/0001", sample_l, sample_r);
        else n_pass++;
        n_chk++;
        if (err_cnt - e0 !== EXP_SHORT_ERR)
            $display("FAIL short_frame_err: got %0d pulses, expected %0d", err_cnt - e0, EXP_SHORT_ERR);
        else n_pass++;
        send_frame(16'h0F0F, 16'hF0F0);
        close_frame();
        n_chk++;
        if (valid_cnt - v0 !== 1 || cap_l !== 16'h0F0F || cap_r !== 16'hF0F0)
            $display("FAIL short_recover: got %0d pulses %h/%h, expected 1 pulse 0f0f/f0f0",
                     valid_cnt - v0, cap_l, cap_r);
        else n_pass++;
        $display("test_short_slot done");
    endtask

    task automatic test_mid_reset();
        int v0;
        send_slot(1'b0, 16'h1111, 32, 1'b0);
        send_slot(1'b1, 16'h2222, 10, 1'b0);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        n_chk++;
        if (sample_l !== 16'h0000 || sample_r !== 16'h0000)
            $display("FAIL midreset_clear: got %h/%h, expected 0000/0000", sample_l, sample_r);
        else n_pass++;
        reset = 1'b0;
        v0 = valid_cnt;
        send_slot(1'b1, 16'h2222, 22, 1'b0);  // rest of the interrupted right slot
        close_frame();                        // relock edge
        n_chk++;
        if (valid_cnt - v0 !== 0) $display("FAIL midreset_relock: got %0d pulses, expected 0", valid_cnt - v0);
        else n_pass++;
        send_frame(16'h2468, 16'h1357);
        close_frame();
        n_chk++;
        if (valid_cnt - v0 !== 1) $display("FAIL midreset_count: got %0d pulses, expected 1", valid_cnt - v0);
        else n_pass++;
        n_chk++;
        if (cap_l !== 16'h2468 || cap_r !== 16'h1357)
            $display("FAIL midreset_data: got %h/%h, expected 2468/1357", cap_l, cap_r);
        else n_pass++;
        $display("test_mid_reset done");
    endtask

    task automatic test_same_clk();
        logic [15:0] tl [8];
        logic [15:0] tr [8];
        int          v0;
        tl[0] = 16'h0001; tr[0] = 16'h8000;
        tl[1] = 16'h8001; tr[1] = 16'h7FFE;
        tl[2] = 16'hC3A5; tr[2] = 16'h5A3C;
        tl[3] = 16'h5A5A; tr[3] = 16'hA5A5;
        tl[4] = 16'h0F0F; tr[4] = 16'hF00F;
        tl[5] = 16'h1357; tr[5] = 16'h9BDF;
        tl[6] = 16'hFFFE; tr[6] = 16'h0002;
        tl[7] = 16'h4000; tr[7] = 16'hBFFF;
        // Lift LRCK with a dummy right slot so the first left slot opens on a fall.
        send_slot(1'b1, 16'h0000, 32, 1'b1);
        v0 = valid_cnt;
        for (int k = 0; k < 8; k++) begin
            send_slot(1'b0, tl[k], 32, 1'b1);
            if (k > 0) begin
                n_chk++;
                if ({cap_l, cap_r} !== {tl[k-1], tr[k-1]})
                    $display("FAIL sameclk%0d_data: got %h/%h, expected %h/%h",
                             k - 1, cap_l, cap_r, tl[k-1], tr[k-1]);
                else n_pass++;
            end
            send_slot(1'b1, tr[k], 32, 1'b1);
        end
        send_slot(1'b0, 16'h0000, 2, 1'b1);
        n_chk++;
        if ({cap_l, cap_r} !== {tl[7], tr[7]})
            $display("FAIL sameclk7_data: got %h/%h, expected %h/%h", cap_l, cap_r, tl[7], tr[7]);
        else n_pass++;
        n_chk++;
        if (valid_cnt - v0 !== 8) $display("FAIL sameclk_count: got %0d pulses, expected 8", valid_cnt - v0);
        else n_pass++;
        n_chk++;
        if (wide_cnt !== 0) $display("FAIL sameclk_width: got %0d wide pulses, expected 0", wide_cnt);
        else n_pass++;
        $display("test_same_clk done");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_sweep();
        test_short_slot();
        test_mid_reset();
        test_same_clk();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_i2s_slave_rx
